// File: rtl/bp_update_sched.sv
// Branch-predictor update scheduler: sweeps the BHT/BTB with clears after reset, then
// queues up to NUM_SUPER resolved branches per cycle and drains one table write per cycle.
module bp_update_sched #(
  parameter int NUM_SUPER       = 2,
  parameter int NUM_BH_IDX_BITS = 4,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_SUPER-1:0]           fu_br_valid,
  input  logic [NUM_SUPER-1:0][63:0]     fu_br_pc,
  input  logic [NUM_SUPER-1:0]           fu_br_taken,
  input  logic [NUM_SUPER-1:0][63:0]     fu_br_target,
  input  logic                           squash,
  output logic                           fu_stall,
  output logic                           upd_valid,
  output logic                           upd_clear,
  output logic [NUM_BH_IDX_BITS-1:0]     upd_idx,
  output logic                           upd_taken,
  output logic [63:0]                    upd_target,
  output logic                           init_busy,
  output logic                           overflow_err
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                       state_r;
  logic [NUM_BH_IDX_BITS-1:0]   init_idx_r;
  logic [PTR_W-1:0]             head_r;
  logic [PTR_W-1:0]             tail_r;
  logic [CNT_W-1:0]             count_r;
  logic                         overflow_r;

  logic [NUM_BH_IDX_BITS-1:0]   q_idx_r    [QUEUE_DEPTH];
  logic                         q_taken_r  [QUEUE_DEPTH];
  logic [63:0]                  q_target_r [QUEUE_DEPTH];

  logic                         pop_s;
  logic [CNT_W-1:0]             free_s;
  logic [CNT_W-1:0]             acc_s;
  logic                         drop_s;
  logic [NUM_SUPER-1:0]         lane_acc_s;
  logic [PTR_W-1:0]             lane_slot_s [NUM_SUPER];
  logic                         unused_s;

  // Only the index field of each PC reaches the tables.
  assign unused_s = ^fu_br_pc;

  assign pop_s  = (state_r == ST_RUN) && (count_r != {CNT_W{1'b0}});
  assign free_s = CNT_W'(QUEUE_DEPTH) - count_r + CNT_W'(pop_s);

  // Compress valid lanes onto consecutive tail slots, lowest lanes first, up to free space.
  always_comb begin
    acc_s  = {CNT_W{1'b0}};
    drop_s = 1'b0;
    lane_acc_s = {NUM_SUPER{1'b0}};
    for (int i = 0; i < NUM_SUPER; i++) begin
      lane_slot_s[i] = {PTR_W{1'b0}};
    end
    for (int i = 0; i < NUM_SUPER; i++) begin
      if ((state_r == ST_RUN) && !squash && fu_br_valid[i]) begin
        if (acc_s < free_s) begin
          lane_acc_s[i]  = 1'b1;
          lane_slot_s[i] = tail_r + acc_s[PTR_W-1:0];
          acc_s          = acc_s + CNT_W'(1);
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        lane_acc_s[i] = 1'b0;
      end
    end
  end

  // Control state: init sweep, queue pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_INIT;
      init_idx_r <= {NUM_BH_IDX_BITS{1'b0}};
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_idx_r <= init_idx_r + NUM_BH_IDX_BITS'(1);
          if (init_idx_r == {NUM_BH_IDX_BITS{1'b1}}) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_INIT;
          end
        end
        ST_RUN: begin
          if (squash) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
          end else begin
            head_r  <= head_r + PTR_W'(pop_s);
            tail_r  <= tail_r + acc_s[PTR_W-1:0];
            count_r <= count_r + acc_s - CNT_W'(pop_s);
            if (drop_s) begin
              overflow_r <= 1'b1;
            end else begin
              overflow_r <= overflow_r;
            end
          end
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end
  end

  // Queue storage; entries are only read once counted in, so no reset is needed.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SUPER; i++) begin
      if (lane_acc_s[i]) begin
        q_idx_r[lane_slot_s[i]]    <= fu_br_pc[i][NUM_BH_IDX_BITS+1:2];
        q_taken_r[lane_slot_s[i]]  <= fu_br_taken[i];
        q_target_r[lane_slot_s[i]] <= fu_br_target[i];
      end
    end
  end

  // Table write port and FU back-pressure; forced quiet while reset is held.
  always_comb begin
    fu_stall   = 1'b1;
    upd_valid  = 1'b0;
    upd_clear  = 1'b0;
    upd_idx    = {NUM_BH_IDX_BITS{1'b0}};
    upd_taken  = 1'b0;
    upd_target = 64'h0;
    init_busy  = 1'b0;
    if (reset) begin
      fu_stall = 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          upd_valid = 1'b1;
          upd_clear = 1'b1;
          upd_idx   = init_idx_r;
          init_busy = 1'b1;
          fu_stall  = 1'b1;
        end
        ST_RUN: begin
          upd_valid  = pop_s;
          upd_idx    = q_idx_r[head_r];
          upd_taken  = q_taken_r[head_r];
          upd_target = q_target_r[head_r];
          fu_stall   = (count_r > CNT_W'(QUEUE_DEPTH - NUM_SUPER));
        end
        default: begin
          fu_stall = 1'b1;
        end
      endcase
    end
  end

  assign overflow_err = overflow_r;

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed self-checking bench for bp_update_sched (NUM_SUPER=2, 16-entry tables, depth-4 queue).
module tb_bp_update_sched;

  logic             clock;
  logic             reset;
  logic [1:0]       fu_br_valid;
  logic [1:0][63:0] fu_br_pc;
  logic [1:0]       fu_br_taken;
  logic [1:0][63:0] fu_br_target;
  logic             squash;
  logic             fu_stall;
  logic             upd_valid;
  logic             upd_clear;
  logic [3:0]       upd_idx;
  logic             upd_taken;
  logic [63:0]      upd_target;
  logic             init_busy;
  logic             overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  bp_update_sched #(.NUM_SUPER(2), .NUM_BH_IDX_BITS(4), .QUEUE_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .fu_br_valid(fu_br_valid), .fu_br_pc(fu_br_pc),
    .fu_br_taken(fu_br_taken), .fu_br_target(fu_br_target), .squash(squash),
    .fu_stall(fu_stall), .upd_valid(upd_valid), .upd_clear(upd_clear), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_target(upd_target), .init_busy(init_busy),
    .overflow_err(overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic t0,
                       input logic [63:0] g0, input logic [63:0] pc1, input logic t1,
                       input logic [63:0] g1);
    fu_br_valid     = v;
    fu_br_pc[0]     = pc0;
    fu_br_taken[0]  = t0;
    fu_br_target[0] = g0;
    fu_br_pc[1]     = pc1;
    fu_br_taken[1]  = t1;
    fu_br_target[1] = g1;
  endtask

  task automatic idle();
    drive(2'b00, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    squash = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    #3;
    n_checks++;
    if ({upd_valid, upd_clear, init_busy, fu_stall, overflow_err} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_outputs: got v/c/busy/stall/ovf=%b required 00010",
               {upd_valid, upd_clear, init_busy, fu_stall, overflow_err});
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({upd_valid, upd_clear, init_busy, fu_stall, upd_idx} !== {4'b1111, 4'(i)}) begin
        n_fail++;
        $display("FAIL sweep_%0d: got v/c/busy/stall=%b idx=%0d required 1111 idx=%0d",
                 i, {upd_valid, upd_clear, init_busy, fu_stall}, upd_idx, i);
      end
      tick();
    end
    n_checks++;
    if ({upd_valid, upd_clear, init_busy, fu_stall} !== 4'b0000) begin
      n_fail++;
      $display("FAIL run_entry: got v/c/busy/stall=%b required 0000",
               {upd_valid, upd_clear, init_busy, fu_stall});
    end
  endtask

  task automatic test_single();
    drive(2'b01, 64'h1010, 1'b1, 64'h2000, 64'h0, 1'b0, 64'h0);
    tick();
    idle();
    n_checks++;
    if ({upd_valid, upd_idx, upd_taken, upd_target} !== {1'b1, 4'd4, 1'b1, 64'h2000}) begin
      n_fail++;
      $display("FAIL single: got v=%b idx=%0d t=%b tgt=%h required v=1 idx=4 t=1 tgt=2000",
               upd_valid, upd_idx, upd_taken, upd_target);
    end
    tick();
    n_checks++;
    if (upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got v=%b required 0", upd_valid);
    end
  endtask

  task automatic test_dual();
    drive(2'b11, 64'h1004, 1'b0, 64'h0, 64'h1008, 1'b1, 64'h3000);
    tick();
    idle();
    n_checks++;
    if ({upd_valid, upd_idx, upd_taken} !== {1'b1, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL dual_lane0: got v=%b idx=%0d t=%b required v=1 idx=1 t=0",
               upd_valid, upd_idx, upd_taken);
    end
    tick();
    n_checks++;
    if ({upd_valid, upd_idx, upd_taken, upd_target} !== {1'b1, 4'd2, 1'b1, 64'h3000}) begin
      n_fail++;
      $display("FAIL dual_lane1: got v=%b idx=%0d t=%b tgt=%h required v=1 idx=2 t=1 tgt=3000",
               upd_valid, upd_idx, upd_taken, upd_target);
    end
    tick();
    n_checks++;
    if (upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dual_drain: got v=%b required 0", upd_valid);
    end
    drive(2'b10, 64'h0, 1'b0, 64'h0, 64'h1030, 1'b1, 64'h4000);
    tick();
    idle();
    n_checks++;
    if ({upd_valid, upd_idx, upd_target} !== {1'b1, 4'd12, 64'h4000}) begin
      n_fail++;
      $display("FAIL lane1_only: got v=%b idx=%0d tgt=%h required v=1 idx=12 tgt=4000",
               upd_valid, upd_idx, upd_target);
    end
    tick();
    n_checks++;
    if (upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lane1_only_drain: got v=%b required 0 (single entry)", upd_valid);
    end
  endtask

  task automatic test_fill_stall();
    drive(2'b11, 64'h2000, 1'b1, 64'hA0, 64'h2004, 1'b0, 64'hA1);
    tick();
    drive(2'b11, 64'h2008, 1'b1, 64'hA2, 64'h200C, 1'b1, 64'hA3);
    n_checks++;
    if ({fu_stall, upd_idx} !== {1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL fill_count2: got stall=%b idx=%0d required stall=0 idx=0", fu_stall, upd_idx);
    end
    tick();
    idle();
    n_checks++;
    if ({fu_stall, upd_valid, upd_idx} !== {1'b1, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL fill_count3: got stall=%b v=%b idx=%0d required stall=1 v=1 idx=1",
               fu_stall, upd_valid, upd_idx);
    end
    tick();
    n_checks++;
    if ({fu_stall, upd_idx} !== {1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL stall_release: got stall=%b idx=%0d required stall=0 idx=2", fu_stall, upd_idx);
    end
    tick();
    tick();
    n_checks++;
    if (upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_drain: got v=%b required 0", upd_valid);
    end
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 64'h2000 + 64'((4 + 2 * k) * 4), 1'b1, 64'h5000 + 64'(k),
            64'h2000 + 64'((5 + 2 * k) * 4), 1'b0, 64'h6000 + 64'(k));
      tick();
      idle();
      n_checks++;
      if ({upd_valid, upd_idx, upd_target} !== {1'b1, 4'(4 + 2 * k), 64'h5000 + 64'(k)}) begin
        n_fail++;
        $display("FAIL wrap_%0d_a: got v=%b idx=%0d tgt=%h required v=1 idx=%0d tgt=%h",
                 k, upd_valid, upd_idx, upd_target, 4 + 2 * k, 64'h5000 + 64'(k));
      end
      tick();
      n_checks++;
      if ({upd_valid, upd_idx, upd_taken} !== {1'b1, 4'(5 + 2 * k), 1'b0}) begin
        n_fail++;
        $display("FAIL wrap_%0d_b: got v=%b idx=%0d t=%b required v=1 idx=%0d t=0",
                 k, upd_valid, upd_idx, upd_taken, 5 + 2 * k);
      end
      tick();
    end
    n_checks++;
    if (upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_drain: got v=%b required 0", upd_valid);
    end
  endtask

  task automatic test_overflow();
    drive(2'b11, 64'h3004, 1'b1, 64'h0, 64'h3008, 1'b1, 64'h0);
    tick();
    drive(2'b11, 64'h300C, 1'b1, 64'h0, 64'h3010, 1'b1, 64'h0);
    tick();
    drive(2'b11, 64'h3014, 1'b1, 64'h0, 64'h3018, 1'b1, 64'h0);
    n_checks++;
    if ({fu_stall, overflow_err, upd_idx} !== {1'b1, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL ovf_count3: got stall=%b ovf=%b idx=%0d required stall=1 ovf=0 idx=2",
               fu_stall, overflow_err, upd_idx);
    end
    tick();
    drive(2'b11, 64'h301C, 1'b1, 64'h0, 64'h3020, 1'b1, 64'h0);
    n_checks++;
    if ({overflow_err, upd_idx} !== {1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL ovf_count3_pop_accept: got ovf=%b idx=%0d required ovf=0 idx=3",
               overflow_err, upd_idx);
    end
    tick();
    idle();
    n_checks++;
    if (overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got ovf=%b required 1", overflow_err);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({upd_valid, upd_idx} !== {1'b1, 4'(4 + k)}) begin
        n_fail++;
        $display("FAIL ovf_drain_%0d: got v=%b idx=%0d required v=1 idx=%0d",
                 k, upd_valid, upd_idx, 4 + k);
      end
      tick();
    end
    n_checks++;
    if ({upd_valid, overflow_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovf_sticky: got v=%b ovf=%b required v=0 ovf=1", upd_valid, overflow_err);
    end
  endtask

  task automatic test_squash();
    drive(2'b11, 64'h4004, 1'b1, 64'h0, 64'h4008, 1'b0, 64'h0);
    tick();
    drive(2'b11, 64'h400C, 1'b1, 64'h0, 64'h4010, 1'b0, 64'h0);
    tick();
    drive(2'b01, 64'h4024, 1'b1, 64'h9999, 64'h0, 1'b0, 64'h0);
    squash = 1'b1;
    n_checks++;
    if ({upd_valid, fu_stall, upd_idx} !== {1'b1, 1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL squash_head: got v=%b stall=%b idx=%0d required v=1 stall=1 idx=2",
               upd_valid, fu_stall, upd_idx);
    end
    tick();
    idle();
    n_checks++;
    if ({upd_valid, fu_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL squash_empty: got v=%b stall=%b required 00", upd_valid, fu_stall);
    end
    tick();
    n_checks++;
    if (upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL squash_lane0_gone: got v=%b idx=%0d required v=0", upd_valid, upd_idx);
    end
    drive(2'b01, 64'h4028, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    tick();
    idle();
    n_checks++;
    if ({upd_valid, upd_idx} !== {1'b1, 4'd10}) begin
      n_fail++;
      $display("FAIL squash_resume: got v=%b idx=%0d required v=1 idx=10", upd_valid, upd_idx);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(2'b11, 64'h5014, 1'b1, 64'h0, 64'h5018, 1'b1, 64'h0);
    tick();
    idle();
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({upd_valid, upd_clear, init_busy, fu_stall, overflow_err} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_async: got v/c/busy/stall/ovf=%b required 00010",
               {upd_valid, upd_clear, init_busy, fu_stall, overflow_err});
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({upd_valid, upd_clear, init_busy, upd_idx} !== {3'b111, 4'(i)}) begin
        n_fail++;
        $display("FAIL resweep_%0d: got v/c/busy=%b idx=%0d required 111 idx=%0d",
                 i, {upd_valid, upd_clear, init_busy}, upd_idx, i);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({upd_valid, init_busy, fu_stall} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_old_gone_%0d: got v/busy/stall=%b required 000",
                 i, {upd_valid, init_busy, fu_stall});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_fill_stall();
    test_overflow();
    test_squash();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
